alu_ctrl: RTL and testbench

Operation sequencer that drives the datapath ALU from the initiator side. It accepts an opcode and operands from the shared bus over a start/done handshake. It issues exactly one one-hot operation strobe (AND, OR, NEG, NOT, SUB, ADD, MUL, ROR, DIV, SHR, SHL) for a bounded number of cycles, then captures the ALU's lo/hi results into the Z register pair. It sits between the control unit and the ALU.

---
 rtl/alu_ctrl_pkg.sv | 52 +++++
 rtl/alu_ctrl_decode.sv | 39 +++
 rtl/alu_ctrl.sv | 153 +++++++++++++++
 tb/tb_alu_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU operation sequencer: opcode map, strobe bit
// positions, FSM state encoding and opcode classification helpers.
package alu_ctrl_pkg;

  localparam int unsigned OpW = 5;

  // Opcode map; every code not listed here is undefined.
  localparam logic [OpW-1:0] OpAdd = 5'h03;
  localparam logic [OpW-1:0] OpSub = 5'h04;
  localparam logic [OpW-1:0] OpShr = 5'h05;
  localparam logic [OpW-1:0] OpShl = 5'h06;
  localparam logic [OpW-1:0] OpRor = 5'h07;
  localparam logic [OpW-1:0] OpAnd = 5'h09;
  localparam logic [OpW-1:0] OpOr  = 5'h0A;
  localparam logic [OpW-1:0] OpMul = 5'h0E;
  localparam logic [OpW-1:0] OpDiv = 5'h0F;
  localparam logic [OpW-1:0] OpNeg = 5'h10;
  localparam logic [OpW-1:0] OpNot = 5'h11;

  // Bit positions inside the one-hot strobe vector.
  localparam int unsigned NumOps = 11;
  localparam int unsigned StrAnd = 0;
  localparam int unsigned StrOr  = 1;
  localparam int unsigned StrNeg = 2;
  localparam int unsigned StrNot = 3;
  localparam int unsigned StrSub = 4;
  localparam int unsigned StrAdd = 5;
  localparam int unsigned StrMul = 6;
  localparam int unsigned StrRor = 7;
  localparam int unsigned StrDiv = 8;
  localparam int unsigned StrShr = 9;
  localparam int unsigned StrShl = 10;

  typedef enum logic [2:0] {
    StIdle,
    StOpb,
    StExec,
    StDone,
    StErr
  } state_e;

  // Unary ops take their single operand from the start cycle and skip OPB.
  function automatic logic is_unary(input logic [OpW-1:0] op);
    return (op == OpNeg) || (op == OpNot);
  endfunction

  // MUL/DIV use the long strobe window and produce a high result word.
  function automatic logic is_muldiv(input logic [OpW-1:0] op);
    return (op == OpMul) || (op == OpDiv);
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode decoder: one-hot ALU strobe vector plus legal/unary/
// muldiv classification.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [OpW-1:0]    opcode,
  output logic [NumOps-1:0] strobe,
  output logic              legal,
  output logic              unary,
  output logic              muldiv
);

  // Map each defined opcode to exactly one strobe bit; undefined codes map to none.
  always_comb begin
    strobe = '0;
    legal  = 1'b1;
    unique case (opcode)
      OpAnd:   strobe[StrAnd] = 1'b1;
      OpOr:    strobe[StrOr]  = 1'b1;
      OpNeg:   strobe[StrNeg] = 1'b1;
      OpNot:   strobe[StrNot] = 1'b1;
      OpSub:   strobe[StrSub] = 1'b1;
      OpAdd:   strobe[StrAdd] = 1'b1;
      OpMul:   strobe[StrMul] = 1'b1;
      OpRor:   strobe[StrRor] = 1'b1;
      OpDiv:   strobe[StrDiv] = 1'b1;
      OpShr:   strobe[StrShr] = 1'b1;
      OpShl:   strobe[StrShl] = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  // Classification is only meaningful for legal codes; the FSM checks legal first.
  always_comb begin
    unary  = is_unary(opcode);
    muldiv = is_muldiv(opcode);
  end

endmodule

// File: rtl/alu_ctrl.sv
// ALU operation sequencer. Accepts opcode/operands over start/done, drives one
// ALU strobe for a bounded window, then captures the result into z_lo/z_hi.
// Build option: ALU_CTRL_ZERO_HI_EN clears z_hi on non-MUL/DIV captures;
// without it z_hi holds its previous value for those ops.
module alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned EXEC_CYCLES   = 1,
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic [OpW-1:0]    opcode,
  input  logic [DATA_W-1:0] bus_in,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic [DATA_W-1:0] y_out,
  output logic [DATA_W-1:0] b_out,
  output logic              op_and,
  output logic              op_or,
  output logic              op_neg,
  output logic              op_not,
  output logic              op_sub,
  output logic              op_add,
  output logic              op_mul,
  output logic              op_ror,
  output logic              op_div,
  output logic              op_shr,
  output logic              op_shl,
  input  logic [DATA_W-1:0] alu_lo,
  input  logic [DATA_W-1:0] alu_hi,
  output logic [DATA_W-1:0] z_lo,
  output logic [DATA_W-1:0] z_hi
);

  // Counter holds remaining EXEC cycles minus one, so it only needs to reach max-1.
  localparam int unsigned CntMax = (MULDIV_CYCLES > EXEC_CYCLES) ? MULDIV_CYCLES : EXEC_CYCLES;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0] ExecLoad = CntW'(EXEC_CYCLES - 1);
  localparam logic [CntW-1:0] MdLoad   = CntW'(MULDIV_CYCLES - 1);

  state_e              state_q;
  logic [OpW-1:0]      opcode_q;
  logic [DATA_W-1:0]   y_q;
  logic [DATA_W-1:0]   b_q;
  logic [CntW-1:0]     cnt_q;
  logic [DATA_W-1:0]   z_lo_q;
  logic [DATA_W-1:0]   z_hi_q;

  logic [OpW-1:0]      dec_opcode;
  logic [NumOps-1:0]   dec_strobe;
  logic                dec_legal;
  logic                dec_unary;
  logic                dec_muldiv;
  logic [NumOps-1:0]   strobe;

  // In IDLE classify the incoming opcode; afterwards the latched one drives everything.
  always_comb begin
    dec_opcode = (state_q == StIdle) ? opcode : opcode_q;
  end

  alu_ctrl_decode u_decode (
    .opcode (dec_opcode),
    .strobe (dec_strobe),
    .legal  (dec_legal),
    .unary  (dec_unary),
    .muldiv (dec_muldiv)
  );

  // Sequencer FSM with operand latches, window counter and result capture.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q  <= StIdle;
      opcode_q <= '0;
      y_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      z_lo_q   <= '0;
      z_hi_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            opcode_q <= opcode;
            y_q      <= bus_in;
            if (!dec_legal) begin
              state_q <= StErr;
            end else if (dec_unary) begin
              b_q     <= bus_in;
              cnt_q   <= dec_muldiv ? MdLoad : ExecLoad;
              state_q <= StExec;
            end else begin
              state_q <= StOpb;
            end
          end
        end
        StOpb: begin
          b_q     <= bus_in;
          cnt_q   <= dec_muldiv ? MdLoad : ExecLoad;
          state_q <= StExec;
        end
        StExec: begin
          if (cnt_q == '0) begin
            z_lo_q <= alu_lo;
            if (dec_muldiv) begin
              z_hi_q <= alu_hi;
            end
`ifdef ALU_CTRL_ZERO_HI_EN
            else begin
              z_hi_q <= '0;
            end
`endif
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StDone:  state_q <= StIdle;
        StErr:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs decode straight from registered state so reset drops them asynchronously.
  always_comb begin
    busy    = (state_q != StIdle);
    done    = (state_q == StDone);
    illegal = (state_q == StErr);
    strobe  = (state_q == StExec) ? dec_strobe : '0;
  end

  assign op_and = strobe[StrAnd];
  assign op_or  = strobe[StrOr];
  assign op_neg = strobe[StrNeg];
  assign op_not = strobe[StrNot];
  assign op_sub = strobe[StrSub];
  assign op_add = strobe[StrAdd];
  assign op_mul = strobe[StrMul];
  assign op_ror = strobe[StrRor];
  assign op_div = strobe[StrDiv];
  assign op_shr = strobe[StrShr];
  assign op_shl = strobe[StrShl];

  assign y_out = y_q;
  assign b_out = b_q;
  assign z_lo  = z_lo_q;
  assign z_hi  = z_hi_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Scoreboard bench for alu_ctrl: stimulus pushes expected results, a negedge
// monitor pops and checks on every done/illegal pulse.
module tb_alu_ctrl;

  localparam int unsigned W  = 32;
  localparam int unsigned EX = 1;
  localparam int unsigned MD = 4;

  logic         clock = 1'b0;
  logic         clear = 1'b0;
  logic         start = 1'b0;
  logic [4:0]   opcode = 5'h00;
  logic [W-1:0] bus_in = '0;
  logic [W-1:0] alu_lo, alu_hi;
  logic         busy, done, illegal;
  logic [W-1:0] y_out, b_out, z_lo, z_hi;
  logic op_and, op_or, op_neg, op_not, op_sub, op_add, op_mul, op_ror, op_div, op_shr, op_shl;

  always #5 clock = ~clock;

  alu_ctrl #(
    .DATA_W        (W),
    .EXEC_CYCLES   (EX),
    .MULDIV_CYCLES (MD)
  ) dut (
    .clock   (clock),
    .clear   (clear),
    .start   (start),
    .opcode  (opcode),
    .bus_in  (bus_in),
    .busy    (busy),
    .done    (done),
    .illegal (illegal),
    .y_out   (y_out),
    .b_out   (b_out),
    .op_and  (op_and),
    .op_or   (op_or),
    .op_neg  (op_neg),
    .op_not  (op_not),
    .op_sub  (op_sub),
    .op_add  (op_add),
    .op_mul  (op_mul),
    .op_ror  (op_ror),
    .op_div  (op_div),
    .op_shr  (op_shr),
    .op_shl  (op_shl),
    .alu_lo  (alu_lo),
    .alu_hi  (alu_hi),
    .z_lo    (z_lo),
    .z_hi    (z_hi)
  );

  // Kind index k: 0 and,1 or,2 neg,3 not,4 sub,5 add,6 mul,7 ror,8 div,9 shr,10 shl
  logic [4:0] codes [11] = '{5'h09, 5'h0A, 5'h10, 5'h11, 5'h04, 5'h03,
                             5'h0E, 5'h07, 5'h0F, 5'h05, 5'h06};
  logic [10:0] str;
  assign str = {op_shl, op_shr, op_div, op_ror, op_mul, op_add,
                op_sub, op_not, op_neg, op_or, op_and};

  int tests = 0;
  int fails = 0;
  longint cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic int kind_of(input logic [4:0] op);
    int k;
    k = -1;
    for (int i = 0; i < 11; i++) if (codes[i] == op) k = i;
    return k;
  endfunction

  // Behavioural ALU; non-MUL/DIV hi is ~lo so a wrong hi capture is visible.
  function automatic void alu_fn(input int k, input logic [W-1:0] y, input logic [W-1:0] b,
                                 output logic [W-1:0] lo, output logic [W-1:0] hi);
    logic [63:0] wide;
    lo = '0;
    hi = '0;
    case (k)
      0: lo = y & b;
      1: lo = y | b;
      2: lo = -b;
      3: lo = ~b;
      4: lo = y - b;
      5: lo = y + b;
      6: begin wide = {32'h0, y} * {32'h0, b}; lo = wide[31:0]; hi = wide[63:32]; end
      7: begin wide = {y, y} >> b[4:0]; lo = wide[31:0]; end
      8: begin
        if (b == 0) begin lo = '1; hi = y; end
        else begin lo = y / b; hi = y % b; end
      end
      9:  lo = y >> b[4:0];
      10: lo = y << b[4:0];
      default: lo = '0;
    endcase
    if (k != 6 && k != 8) hi = ~lo;
  endfunction

  // Environment ALU: valid result only once the strobe has been held long enough.
  int unsigned held;
  always @(posedge clock or negedge clear) begin
    if (!clear) held <= 0;
    else if (str != 0) held <= held + 1;
    else held <= 0;
  end

  always_comb begin
    logic [W-1:0] lo_v, hi_v;
    int k;
    int unsigned need;
    alu_lo = 32'hA5A5_5A5A;
    alu_hi = 32'h5A5A_A5A5;
    lo_v = '0;
    hi_v = '0;
    k = -1;
    for (int i = 0; i < 11; i++) if (str[i]) k = i;
    need = (op_mul || op_div) ? MD - 1 : EX - 1;
    if (k >= 0 && held >= need) begin
      alu_fn(k, y_out, b_out, lo_v, hi_v);
      alu_lo = lo_v;
      alu_hi = hi_v;
    end
  end

  typedef struct {
    bit          ill;
    logic [W-1:0] zlo;
    logic [W-1:0] zhi;
    logic [W-1:0] y;
    logic [W-1:0] b;
    logic [10:0] mask;
    int          strc;
    longint      cyc;
  } exp_t;

  exp_t q[$];
  logic [W-1:0] m_zlo = '0;
  logic [W-1:0] m_zhi = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected response for a start sampled at the next rising edge.
  task automatic push_exp(input logic [4:0] op, input logic [W-1:0] y, input logic [W-1:0] b);
    exp_t e;
    int k;
    bit md;
    logic [W-1:0] lo, hi, beff;
    k = kind_of(op);
    md = (k == 6 || k == 8);
    e.ill = (k < 0);
    e.y = y;
    if (k < 0) begin
      e.mask = '0;
      e.strc = 0;
      e.cyc = cyc + 1;
      e.b = '0;
    end else begin
      beff = (k == 2 || k == 3) ? y : b;
      e.b = beff;
      e.mask = 11'(1) << k;
      e.strc = md ? MD : EX;
      e.cyc = cyc + ((k == 2 || k == 3) ? 1 : 2) + e.strc;
      alu_fn(k, y, beff, lo, hi);
      m_zlo = lo;
      if (md) m_zhi = hi;
`ifdef ALU_CTRL_ZERO_HI_EN
      else m_zhi = '0;
`endif
    end
    e.zlo = m_zlo;
    e.zhi = m_zhi;
    q.push_back(e);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      if (!busy) return;
    end
    tests++;
    fails++;
    $display("FAIL wait_idle: busy still 1 after 64 cycles, expected 0");
  endtask

  // Issue one transaction from an IDLE negedge: Y/unary operand first, B next cycle.
  task automatic issue(input logic [4:0] op, input logic [W-1:0] y, input logic [W-1:0] b);
    push_exp(op, y, b);
    start = 1'b1;
    opcode = op;
    bus_in = y;
    @(negedge clock);
    start = 1'b0;
    bus_in = b;
    wait_idle();
  endtask

  // Monitor: one-hot check each strobe cycle; pop and compare on done/illegal.
  logic [10:0] acc_mask;
  int          acc_cnt;
  exp_t        me;
  always @(negedge clock) begin
    if (!clear) begin
      acc_mask = '0;
      acc_cnt = 0;
    end else begin
      if (str != 0) begin
        check("onehot", 64'($countones(str)), 64'd1);
        acc_mask |= str;
        acc_cnt++;
      end
      if (done || illegal) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_pulse: done=%0b illegal=%0b with no pending request", done,
                   illegal);
        end else begin
          me = q.pop_front();
          check("illegal", 64'(illegal), 64'(me.ill));
          check("done", 64'(done), 64'(!me.ill));
          check("latency", 64'(cyc), 64'(me.cyc));
          check("z_lo", 64'(z_lo), 64'(me.zlo));
          check("z_hi", 64'(z_hi), 64'(me.zhi));
          check("strobe_mask", 64'(acc_mask), 64'(me.mask));
          check("strobe_cycles", 64'(acc_cnt), 64'(me.strc));
          if (!me.ill) begin
            check("y_out", 64'(y_out), 64'(me.y));
            check("b_out", 64'(b_out), 64'(me.b));
          end
        end
        acc_mask = '0;
        acc_cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] y2, b2;
    logic [4:0]   rop;
    // Reset state
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done | illegal), 64'd0);
    check("rst_strobes", 64'(str), 64'd0);
    check("rst_z", {z_hi, z_lo}, 64'd0);
    check("rst_yb", {y_out, b_out}, 64'd0);
    repeat (2) @(negedge clock);
    clear = 1'b1;
    @(negedge clock);

    // Directed cases from the plan
    issue(5'h0E, 32'h0001_0000, 32'h0001_0000);   // MUL: z_hi=1, z_lo=0
    issue(5'h03, 32'd5, 32'd7);                   // ADD: z_lo=12, z_hi held/cleared
    issue(5'h10, 32'd1, 32'h1234_5678);           // NEG unary: z_lo=FFFF_FFFF
    issue(5'h1F, 32'hDEAD_0001, 32'h0);           // undefined: illegal pulse, Z unchanged

    // start held high through a DIV; only the following IDLE cycle accepts
    push_exp(5'h0F, 32'd1000, 32'd7);
    start = 1'b1;
    opcode = 5'h0F;
    bus_in = 32'd1000;
    @(negedge clock);
    opcode = 5'h03;
    bus_in = 32'd7;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (!busy) break;
      bus_in = $urandom;
    end
    y2 = $urandom;
    b2 = $urandom;
    bus_in = y2;
    push_exp(5'h03, y2, b2);
    @(negedge clock);
    start = 1'b0;
    bus_in = b2;
    wait_idle();

    // Randomized mix of legal and undefined opcodes
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) < 8) begin
        rop = codes[$urandom_range(0, 10)];
      end else begin
        rop = 5'($urandom_range(0, 31));
        while (kind_of(rop) >= 0) rop = 5'($urandom_range(0, 31));
      end
      issue(rop, $urandom, ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom);
    end

    // Reset in the middle of a MUL
    start = 1'b1;
    opcode = 5'h0E;
    bus_in = 32'hFFFF_0003;
    @(negedge clock);
    start = 1'b0;
    bus_in = 32'h0000_0011;
    for (int i = 0; i < 10; i++) begin
      if (op_mul) break;
      @(negedge clock);
    end
    check("mul_strobe_seen", 64'(op_mul), 64'd1);
    @(negedge clock);
    #1 clear = 1'b0;
    #1;
    check("abort_strobe", 64'(str), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_z", {z_hi, z_lo}, 64'd0);
    m_zlo = '0;
    m_zhi = '0;
    repeat (2) @(negedge clock);
    clear = 1'b1;
    repeat (8) @(negedge clock);
    issue(5'h03, 32'd2, 32'd3);
    check("post_reset_add", 64'(z_lo), 64'd5);

    repeat (5) @(negedge clock);
    check("queue_empty", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
